// File: rtl/pe_arb_pkg.sv
// Shared types and constants for the PE output arbiter.
package pe_arb_pkg;

  typedef enum logic {
    OUT_EMPTY,
    OUT_FULL
  } out_state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_L0,
    GNT_L1
  } grant_t;

  localparam logic SRC_L0 = 1'b0;
  localparam logic SRC_L1 = 1'b1;

endpackage

// File: rtl/pe_arb_starve_ctr.sv
// Starvation guard for the secondary requester (L1) of the PE output arbiter.
// Counts consecutive L0 grants taken while L1 is waiting and raises 'starve'
// once STARVE_LIMIT of them have happened, so the next contended grant goes to L1.
module pe_arb_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic l0_win,
  input  logic l1_win,
  input  logic l1_valid,
  output logic starve
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;

  // Count L0 wins while L1 waits; restart whenever L1 is served or stops asking.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (l1_win || !l1_valid) begin
      starve_cnt <= '0;
    end else if (l0_win && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  assign starve = l1_valid && (starve_cnt == LIMIT);

endmodule

// File: rtl/pe_out_arbiter.sv
// Two-requester arbiter for the PE output path with a one-entry registered
// output stage. L0 has priority; L1 is protected from starvation when the
// design is built with PE_ARB_STARVE_GUARD_EN defined, otherwise strict priority.
module pe_out_arbiter
  import pe_arb_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] L0_data,
  input  logic             L0_valid,
  output logic             L0_ready,
  input  logic [WIDTH-1:0] L1_data,
  input  logic             L1_valid,
  output logic             L1_ready,
  output logic [WIDTH-1:0] R_data,
  output logic             R_valid,
  output logic             R_src,
  input  logic             R_ready
);

  out_state_t state;
  grant_t     grant;
  logic       load_en;
  logic       starve;

  // The output register can take a new word when empty or when it drains this cycle.
  assign load_en = (state == OUT_EMPTY) || R_ready;

  // Pick the winner for this cycle; nobody is granted while in reset.
  // NOTE: grant gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant = GNT_NONE;
    if (!rst && load_en) begin
      if (L0_valid && (!L1_valid || !starve)) begin
        grant = GNT_L0;
      end else if (L1_valid) begin
        grant = GNT_L1;
      end
    end
  end

  assign L0_ready = (grant == GNT_L0);
  assign L1_ready = (grant == GNT_L1);

`ifdef PE_ARB_STARVE_GUARD_EN
  pe_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk     (clk),
    .rst     (rst),
    .l0_win  (grant == GNT_L0),
    .l1_win  (grant == GNT_L1),
    .l1_valid(L1_valid),
    .starve  (starve)
  );
`else
  // Strict priority: L1 only wins when L0 is idle.
  assign starve = 1'b0;
`endif

  // Output stage: load the winner, hold under backpressure, empty when drained.
  // NOTE: the payload register is reset too, because R_data must read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= OUT_EMPTY;
      R_data <= '0;
      R_src  <= SRC_L0;
    end else begin
      case (state)
        OUT_EMPTY: begin
          if (grant != GNT_NONE) state <= OUT_FULL;
        end
        OUT_FULL: begin
          if (R_ready && (grant == GNT_NONE)) state <= OUT_EMPTY;
        end
        default: state <= OUT_EMPTY;
      endcase
      if (grant == GNT_L0) begin
        R_data <= L0_data;
        R_src  <= SRC_L0;
      end else if (grant == GNT_L1) begin
        R_data <= L1_data;
        R_src  <= SRC_L1;
      end
    end
  end

  assign R_valid = (state == OUT_FULL);

  // Legal starvation limits are 1..255.
  assert property (@(posedge clk) (STARVE_LIMIT >= 1) && (STARVE_LIMIT <= 255));

endmodule

// File: tb/tb_pe_out_arbiter.sv
// Self-checking bench for pe_out_arbiter: directed scenarios plus a randomized
// run compared against a transaction-level reference model.
module tb_pe_out_arbiter;

  localparam int WIDTH = 8;
  localparam int LIMIT = 4;
`ifdef PE_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] L0_data, L1_data, R_data;
  logic             L0_valid, L1_valid, L0_ready, L1_ready;
  logic             R_valid, R_src, R_ready;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: contents of the output slot and the L0-win streak while L1 waits.
  bit         m_valid = 1'b0;
  logic [7:0] m_data  = '0;
  bit         m_src   = 1'b0;
  int         m_cnt   = 0;

  pe_out_arbiter #(
    .WIDTH       (WIDTH),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .L0_data (L0_data),
    .L0_valid(L0_valid),
    .L0_ready(L0_ready),
    .L1_data (L1_data),
    .L1_valid(L1_valid),
    .L1_ready(L1_ready),
    .R_data  (R_data),
    .R_valid (R_valid),
    .R_src   (R_src),
    .R_ready (R_ready)
  );

  always #5 clk = ~clk;

  // 0 = nobody, 1 = L0, 2 = L1 wins at the coming edge.
  function automatic int model_grant();
    if (rst) return 0;
    if (m_valid && !R_ready) return 0;
    if (L0_valid && L1_valid) return (GUARD && (m_cnt >= LIMIT)) ? 2 : 1;
    if (L0_valid) return 1;
    if (L1_valid) return 2;
    return 0;
  endfunction

  // Apply one clock edge to both DUT and model; returns at the next falling edge.
  task automatic advance();
    int g;
    g = model_grant();
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_src = 1'b0; m_cnt = 0;
    end else begin
      if (!L1_valid || g == 2) m_cnt = 0;
      else if (g == 1 && m_cnt < LIMIT) m_cnt++;
      if (g == 1) begin
        m_valid = 1'b1; m_data = L0_data; m_src = 1'b0;
      end else if (g == 2) begin
        m_valid = 1'b1; m_data = L1_data; m_src = 1'b1;
      end else if (R_ready) begin
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rst = 1'b0; L0_valid = 1'b0; L1_valid = 1'b0; R_ready = 1'b1;
    repeat (n) advance();
  endtask

  task automatic test_reset();
    rst = 1'b1; L0_valid = 1'b1; L1_valid = 1'b1; R_ready = 1'b1;
    L0_data = 8'h5A; L1_data = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (L0_ready !== 1'b0 || L1_ready !== 1'b0)
        $display("FAIL reset_ready: got L0=%b L1=%b expected 0/0", L0_ready, L1_ready);
      else n_pass++;
      n_total++;
      if (R_valid !== 1'b0) $display("FAIL reset_rvalid: got %b expected 0", R_valid);
      else n_pass++;
      advance();
    end
    #1;
    n_total++;
    if (R_data !== 8'h00 || R_src !== 1'b0)
      $display("FAIL reset_rdata: got data=%h src=%b expected 00/0", R_data, R_src);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if (L0_ready !== 1'b1 || L1_ready !== 1'b0)
      $display("FAIL post_reset_grant: got L0=%b L1=%b expected 1/0", L0_ready, L1_ready);
    else n_pass++;
    advance();
    #1;
    n_total++;
    if (R_valid !== 1'b1 || R_data !== 8'h5A || R_src !== 1'b0)
      $display("FAIL first_word: got v=%b data=%h src=%b expected 1/5a/0", R_valid, R_data, R_src);
    else n_pass++;
    idle(2);
  endtask

  task automatic test_single_source();
    logic [7:0] vals [3];
    vals = '{8'h11, 8'h22, 8'h33};
    L0_valid = 1'b0; L1_valid = 1'b1; R_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) L1_data = vals[i];
      else L1_valid = 1'b0;
      #1;
      if (i > 0) begin
        n_total++;
        if (R_valid !== 1'b1 || R_data !== vals[i-1] || R_src !== 1'b1)
          $display("FAIL single_out: got v=%b data=%h src=%b expected 1/%h/1",
                   R_valid, R_data, R_src, vals[i-1]);
        else n_pass++;
      end
      if (i < 3) begin
        n_total++;
        if (L1_ready !== 1'b1 || L0_ready !== 1'b0)
          $display("FAIL single_ready: got L0=%b L1=%b expected 0/1", L0_ready, L1_ready);
        else n_pass++;
      end
      advance();
    end
    #1;
    n_total++;
    if (R_valid !== 1'b0) $display("FAIL single_drain: got %b expected 0", R_valid);
    else n_pass++;
    idle(1);
  endtask

  task automatic test_backpressure();
    L0_valid = 1'b1; L1_valid = 1'b0; R_ready = 1'b0; L0_data = 8'hA5;
    #1;
    n_total++;
    if (L0_ready !== 1'b1) $display("FAIL bp_first_load: got %b expected 1", L0_ready);
    else n_pass++;
    advance();
    L0_data = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_total++;
      if (R_valid !== 1'b1 || R_data !== 8'hA5 || R_src !== 1'b0 || L0_ready !== 1'b0)
        $display("FAIL bp_hold: got v=%b data=%h src=%b rdy=%b expected 1/a5/0/0",
                 R_valid, R_data, R_src, L0_ready);
      else n_pass++;
      advance();
    end
    R_ready = 1'b1;
    #1;
    n_total++;
    if (L0_ready !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", L0_ready);
    else n_pass++;
    advance();
    #1;
    n_total++;
    if (R_valid !== 1'b1 || R_data !== 8'h3C)
      $display("FAIL bp_next_word: got v=%b data=%h expected 1/3c", R_valid, R_data);
    else n_pass++;
    idle(2);
  endtask

`ifdef PE_ARB_STARVE_GUARD_EN
  task automatic test_guard_contention();
    bit exp_src [10];
    for (int i = 0; i < 10; i++) exp_src[i] = ((i % (LIMIT + 1)) == LIMIT);
    L0_valid = 1'b1; L1_valid = 1'b1; R_ready = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      L0_data = 8'($urandom); L1_data = 8'($urandom);
      #1;
      if (i > 0) begin
        n_total++;
        if (R_valid !== 1'b1 || R_src !== exp_src[i-1])
          $display("FAIL guard_src[%0d]: got v=%b src=%b expected 1/%b", i-1, R_valid, R_src, exp_src[i-1]);
        else n_pass++;
      end
      if (i < 10) begin
        n_total++;
        if (L0_ready !== !exp_src[i] || L1_ready !== exp_src[i])
          $display("FAIL guard_ready[%0d]: got L0=%b L1=%b expected %b/%b",
                   i, L0_ready, L1_ready, !exp_src[i], exp_src[i]);
        else n_pass++;
      end
      if (i == 10) L1_valid = 1'b0;
      advance();
    end
    idle(2);
  endtask

  task automatic test_guard_restart();
    L0_valid = 1'b1; L1_valid = 1'b1; R_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      L1_valid = (i != 3);
      #1;
      n_total++;
      if (L0_ready !== (i != 8) || L1_ready !== (i == 8))
        $display("FAIL guard_restart[%0d]: got L0=%b L1=%b expected %b/%b",
                 i, L0_ready, L1_ready, (i != 8), (i == 8));
      else n_pass++;
      advance();
    end
    idle(2);
  endtask
`else
  task automatic test_strict_priority();
    L0_valid = 1'b1; L1_valid = 1'b1; R_ready = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      #1;
      if (i > 0) begin
        n_total++;
        if (R_valid !== 1'b1 || R_src !== 1'b0)
          $display("FAIL strict_src[%0d]: got v=%b src=%b expected 1/0", i-1, R_valid, R_src);
        else n_pass++;
      end
      if (i < 20) begin
        n_total++;
        if (L1_ready !== 1'b0 || L0_ready !== 1'b1)
          $display("FAIL strict_ready[%0d]: got L0=%b L1=%b expected 1/0", i, L0_ready, L1_ready);
        else n_pass++;
      end
      if (i == 20) begin
        L0_valid = 1'b0; L1_valid = 1'b0;
      end
      advance();
    end
    idle(2);
  endtask
`endif

  task automatic test_random();
    int g;
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 59) == 0);
      L0_valid = ($urandom_range(0, 99) < 60);
      L1_valid = ($urandom_range(0, 99) < 60);
      R_ready  = ($urandom_range(0, 99) < 70);
      L0_data  = 8'($urandom);
      L1_data  = 8'($urandom);
      #1;
      g = model_grant();
      n_total++;
      if (L0_ready !== (g == 1) || L1_ready !== (g == 2))
        $display("FAIL rand_ready[%0d]: got L0=%b L1=%b expected %b/%b",
                 i, L0_ready, L1_ready, (g == 1), (g == 2));
      else n_pass++;
      n_total++;
      if (R_valid !== m_valid) $display("FAIL rand_rvalid[%0d]: got %b expected %b", i, R_valid, m_valid);
      else n_pass++;
      if (m_valid) begin
        n_total++;
        if (R_data !== m_data || R_src !== m_src)
          $display("FAIL rand_rdata[%0d]: got %h/%b expected %h/%b", i, R_data, R_src, m_data, m_src);
        else n_pass++;
      end
      advance();
    end
    idle(2);
  endtask

  initial begin
    rst = 1'b1; L0_valid = 1'b0; L1_valid = 1'b0; R_ready = 1'b0;
    L0_data = '0; L1_data = '0;
    @(negedge clk);
    test_reset();
    test_single_source();
    test_backpressure();
`ifdef PE_ARB_STARVE_GUARD_EN
    test_guard_contention();
    test_guard_restart();
`else
    test_strict_priority();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
